// File: rtl/collision_scanner_pkg.sv
// Shared definitions for the collision scanner: parameter defaults, probe slot
// indices, FSM state encoding and a width helper.
package collision_scanner_pkg;

    localparam int DEF_N_SEG           = 7;
    localparam int DEF_N_PROBE         = 3;
    localparam int DEF_POS_W           = 8;
    localparam int DEF_COOLDOWN_FRAMES = 4;

    localparam int PROBE_PLAYER = 0;
    localparam int PROBE_SWORD  = 1;
    localparam int PROBE_SHEEP  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SNAP    = 2'd1,
        ST_SCAN    = 2'd2,
        ST_PUBLISH = 2'd3
    } scan_state_t;

    // $clog2 that never returns less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// Bus between the entity logic (master) and the collision scanner (slave):
// frame trigger, position/enable inputs and the published hit results.
interface collision_scanner_if #(
    parameter int N_SEG   = 7,
    parameter int N_PROBE = 3,
    parameter int POS_W   = 8,
    parameter int IDX_W   = (N_SEG > 2) ? $clog2(N_SEG) : 1
);
    logic                       frame_start;
    logic [N_SEG*POS_W-1:0]     seg_pos;
    logic [N_SEG-1:0]           seg_active;
    logic [N_PROBE*POS_W-1:0]   probe_pos;
    logic [N_PROBE-1:0]         probe_en;
    logic [N_PROBE-1:0]         hit_level;
    logic [N_PROBE*IDX_W-1:0]   hit_seg;
    logic [N_PROBE-1:0]         hit_pulse;
    logic                       result_valid;
    logic                       busy;
    logic                       overrun;

    modport master (
        output frame_start, seg_pos, seg_active, probe_pos, probe_en,
        input  hit_level, hit_seg, hit_pulse, result_valid, busy, overrun
    );

    modport slave (
        input  frame_start, seg_pos, seg_active, probe_pos, probe_en,
        output hit_level, hit_seg, hit_pulse, result_valid, busy, overrun
    );
endinterface

// File: rtl/collision_scanner_compare.sv
// Combinational compare of one dragon segment against every probe; a probe
// matches only when enabled, the segment is visible and the positions are equal.
module collision_scanner_compare
    import collision_scanner_pkg::*;
#(
    parameter int N_PROBE = DEF_N_PROBE,
    parameter int POS_W   = DEF_POS_W
) (
    input  logic [POS_W-1:0]         i_seg_pos,
    input  logic                     i_seg_active,
    input  logic [N_PROBE*POS_W-1:0] i_probe_pos,
    input  logic [N_PROBE-1:0]       i_probe_en,
    output logic [N_PROBE-1:0]       o_match
);
    for (genvar gi = 0; gi < N_PROBE; gi++) begin : g_probe
        assign o_match[gi] = i_probe_en[gi] & i_seg_active
                           & (i_probe_pos[gi*POS_W +: POS_W] == i_seg_pos);
    end
endmodule

// File: rtl/collision_scanner.sv
// Once-per-frame collision scanner: snapshots the scene, walks one segment per
// cycle against all probes and publishes hit levels, lowest hit index and pulses.
module collision_scanner
    import collision_scanner_pkg::*;
#(
    parameter int N_SEG           = DEF_N_SEG,
    parameter int N_PROBE         = DEF_N_PROBE,
    parameter int POS_W           = DEF_POS_W,
    parameter int COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES
) (
    input logic                clk,
    input logic                rst_n,
    collision_scanner_if.slave bus
);
    localparam int IDX_W  = clog2_min1(N_SEG);
    localparam int COOL_W = clog2_min1(COOLDOWN_FRAMES + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SEG - 1);
    localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_FRAMES);

    scan_state_t                r_state;
    logic [IDX_W-1:0]           r_idx;
    logic [N_SEG*POS_W-1:0]     r_snap_seg;
    logic [N_SEG-1:0]           r_snap_active;
    logic [N_PROBE*POS_W-1:0]   r_snap_probe;
    logic [N_PROBE-1:0]         r_snap_en;
    logic [N_PROBE-1:0]         r_acc_hit;
    logic [N_PROBE*IDX_W-1:0]   r_acc_seg;
    logic [COOL_W-1:0]          r_cool [N_PROBE];
    logic [N_PROBE-1:0]         r_cool_ok;
    logic [N_PROBE-1:0]         r_hit_level;
    logic [N_PROBE*IDX_W-1:0]   r_hit_seg;
    logic [N_PROBE-1:0]         r_hit_pulse;
    logic                       r_result_valid;
    logic                       r_busy;
    logic                       r_overrun;

    logic [POS_W-1:0]           w_seg_arr [N_SEG];
    logic [POS_W-1:0]           w_cur_seg;
    logic                       w_cur_active;
    logic [N_PROBE-1:0]         w_match;
    logic [N_PROBE-1:0]         w_acc_hit_next;
    logic [N_PROBE*IDX_W-1:0]   w_acc_seg_next;
    logic [N_PROBE-1:0]         w_pulse_next;
    logic                       w_frame_go;
    logic                       w_last_scan;

    for (genvar gi = 0; gi < N_SEG; gi++) begin : g_seg
        assign w_seg_arr[gi] = r_snap_seg[gi*POS_W +: POS_W];
    end

    assign w_cur_seg    = w_seg_arr[r_idx];
    assign w_cur_active = r_snap_active[r_idx];
    assign w_frame_go   = (r_state == ST_IDLE) && bus.frame_start;
    assign w_last_scan  = (r_state == ST_SCAN) && (r_idx == LAST_IDX);

    collision_scanner_compare #(
        .N_PROBE (N_PROBE),
        .POS_W   (POS_W)
    ) u_compare (
        .i_seg_pos    (w_cur_seg),
        .i_seg_active (w_cur_active),
        .i_probe_pos  (r_snap_probe),
        .i_probe_en   (r_snap_en),
        .o_match      (w_match)
    );

    // First match latches the index, so scanning upward keeps the lowest one.
    for (genvar gi = 0; gi < N_PROBE; gi++) begin : g_acc
        assign w_acc_hit_next[gi] = r_acc_hit[gi] | w_match[gi];
        assign w_acc_seg_next[gi*IDX_W +: IDX_W] =
            (w_match[gi] && !r_acc_hit[gi]) ? r_idx : r_acc_seg[gi*IDX_W +: IDX_W];
        assign w_pulse_next[gi] = w_acc_hit_next[gi] & r_cool_ok[gi];
    end

    // Cooldown expiry is judged on the counter value before this frame's decrement,
    // so a probe stays muted for exactly COOLDOWN_FRAMES frames after it fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < N_PROBE; p++) begin
                r_cool[p] <= '0;
            end
            r_cool_ok <= '0;
        end else begin
            for (int p = 0; p < N_PROBE; p++) begin
                if (w_frame_go) begin
                    r_cool_ok[p] <= (r_cool[p] == '0);
                    if (r_cool[p] != '0) begin
                        r_cool[p] <= r_cool[p] - 1'b1;
                    end
                end else if (w_last_scan && w_pulse_next[p]) begin
                    r_cool[p] <= COOL_LOAD;
                end
            end
        end
    end

    // Results are registered on the final scan edge so they are visible
    // during the PUBLISH cycle itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_idx          <= '0;
            r_snap_seg     <= '0;
            r_snap_active  <= '0;
            r_snap_probe   <= '0;
            r_snap_en      <= '0;
            r_acc_hit      <= '0;
            r_acc_seg      <= '0;
            r_hit_level    <= '0;
            r_hit_seg      <= '0;
            r_hit_pulse    <= '0;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_hit_pulse    <= '0;
            if (bus.frame_start && r_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        r_state <= ST_SNAP;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SNAP: begin
                    r_snap_seg    <= bus.seg_pos;
                    r_snap_active <= bus.seg_active;
                    r_snap_probe  <= bus.probe_pos;
                    r_snap_en     <= bus.probe_en;
                    r_acc_hit     <= '0;
                    r_acc_seg     <= '0;
                    r_idx         <= '0;
                    r_state       <= ST_SCAN;
                end
                ST_SCAN: begin
                    r_acc_hit <= w_acc_hit_next;
                    r_acc_seg <= w_acc_seg_next;
                    if (r_idx == LAST_IDX) begin
                        r_state        <= ST_PUBLISH;
                        r_hit_level    <= w_acc_hit_next;
                        r_hit_seg      <= w_acc_seg_next;
                        r_hit_pulse    <= w_pulse_next;
                        r_result_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.hit_level    = r_hit_level;
    assign bus.hit_seg      = r_hit_seg;
    assign bus.hit_pulse    = r_hit_pulse;
    assign bus.result_valid = r_result_valid;
    assign bus.busy         = r_busy;
    assign bus.overrun      = r_overrun;

endmodule

// File: tb/tb_collision_scanner.sv
// Scoreboard bench: directed frames on the default 7x3 scanner plus a randomised
// 16x5 sweep checked against a behavioural model.
module tb_collision_scanner;
    import collision_scanner_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    collision_scanner_if #(.N_SEG(7),  .N_PROBE(3), .POS_W(8)) bus_a ();
    collision_scanner_if #(.N_SEG(16), .N_PROBE(5), .POS_W(8)) bus_b ();

    collision_scanner #(.N_SEG(7), .N_PROBE(3), .POS_W(8), .COOLDOWN_FRAMES(4)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    collision_scanner #(.N_SEG(16), .N_PROBE(5), .POS_W(8), .COOLDOWN_FRAMES(4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        int         cyc;
        logic [2:0] lvl;
        logic [8:0] seg;
        logic [2:0] pulse;
        string      tag;
    } exp_a_t;

    typedef struct {
        int          cyc;
        logic [4:0]  lvl;
        logic [19:0] seg;
        logic [4:0]  pulse;
        string       tag;
    } exp_b_t;

    exp_a_t q_a[$];
    exp_b_t q_b[$];
    exp_a_t ea;
    exp_b_t eb;
    int     cool_b[5];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got=0x%0h required=0x%0h (cyc=%0d)", name, got, req, cyc);
        end
    endtask

    // Scoreboard monitors: pop one expectation per published result.
    always @(negedge clk) begin
        if (bus_a.result_valid) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_valid", 32'(bus_a.result_valid), 32'd0);
            end else begin
                ea = q_a.pop_front();
                $display("a %s: cyc=%0d lvl=%b seg=%h pulse=%b", ea.tag, cyc,
                         bus_a.hit_level, bus_a.hit_seg, bus_a.hit_pulse);
                chk({ea.tag, "_cyc"},   32'(cyc),             32'(ea.cyc));
                chk({ea.tag, "_lvl"},   32'(bus_a.hit_level), 32'(ea.lvl));
                chk({ea.tag, "_seg"},   32'(bus_a.hit_seg),   32'(ea.seg));
                chk({ea.tag, "_pulse"}, 32'(bus_a.hit_pulse), 32'(ea.pulse));
            end
        end else begin
            chk("a_pulse_idle", 32'(bus_a.hit_pulse), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (bus_b.result_valid) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_valid", 32'(bus_b.result_valid), 32'd0);
            end else begin
                eb = q_b.pop_front();
                $display("b %s: cyc=%0d lvl=%b seg=%h pulse=%b", eb.tag, cyc,
                         bus_b.hit_level, bus_b.hit_seg, bus_b.hit_pulse);
                chk({eb.tag, "_cyc"},   32'(cyc),             32'(eb.cyc));
                chk({eb.tag, "_lvl"},   32'(bus_b.hit_level), 32'(eb.lvl));
                chk({eb.tag, "_seg"},   32'(bus_b.hit_seg),   32'(eb.seg));
                chk({eb.tag, "_pulse"}, 32'(bus_b.hit_pulse), 32'(eb.pulse));
            end
        end else begin
            chk("b_pulse_idle", 32'(bus_b.hit_pulse), 32'd0);
        end
    end

    task automatic seg_a(input int i, input logic [7:0] pos, input logic act);
        bus_a.seg_pos[i*8 +: 8] = pos;
        bus_a.seg_active[i]     = act;
    endtask

    task automatic probe_a(input int p, input logic [7:0] pos, input logic en);
        bus_a.probe_pos[p*8 +: 8] = pos;
        bus_a.probe_en[p]         = en;
    endtask

    task automatic defaults_a();
        for (int i = 0; i < 7; i++) seg_a(i, 8'hF0 + 8'(i), 1'b1);
        for (int p = 0; p < 3; p++) probe_a(p, 8'(p), 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Result expected N_SEG+2 cycles after the cycle frame_start is high.
    task automatic frame_a(input string tag, input logic [2:0] lvl,
                           input logic [8:0] seg, input logic [2:0] pulse);
        exp_a_t e;
        @(posedge clk); #1;
        bus_a.frame_start = 1'b1;
        e.cyc = cyc + 9; e.lvl = lvl; e.seg = seg; e.pulse = pulse; e.tag = tag;
        q_a.push_back(e);
        @(posedge clk); #1;
        bus_a.frame_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic frame_b(input string tag, input logic [4:0] lvl,
                           input logic [19:0] seg, input logic [4:0] pulse);
        exp_b_t e;
        @(posedge clk); #1;
        bus_b.frame_start = 1'b1;
        e.cyc = cyc + 18; e.lvl = lvl; e.seg = seg; e.pulse = pulse; e.tag = tag;
        q_b.push_back(e);
        @(posedge clk); #1;
        bus_b.frame_start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
    endtask

    initial begin
        int          t0;
        logic [4:0]  m_lvl;
        logic [19:0] m_seg;
        logic [4:0]  m_pulse;
        logic        ok;

        bus_a.frame_start = 1'b0;
        bus_b.frame_start = 1'b0;
        bus_b.seg_pos     = '0;
        bus_b.seg_active  = '0;
        bus_b.probe_pos   = '0;
        bus_b.probe_en    = '0;
        defaults_a();
        for (int p = 0; p < 5; p++) cool_b[p] = 0;

        // Reset values, then an abort mid-scan and a clean rescan
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_rst_level",  32'(bus_a.hit_level),    32'd0);
        chk("t1_rst_seg",    32'(bus_a.hit_seg),      32'd0);
        chk("t1_rst_pulse",  32'(bus_a.hit_pulse),    32'd0);
        chk("t1_rst_valid",  32'(bus_a.result_valid), 32'd0);
        chk("t1_rst_busy",   32'(bus_a.busy),         32'd0);
        chk("t1_rst_ovr",    32'(bus_a.overrun),      32'd0);
        rst_n = 1'b1;
        seg_a(6, 8'h5A, 1'b1);
        probe_a(PROBE_SHEEP, 8'h5A, 1'b1);
        frame_a("t1_pre", 3'b100, 9'b110_000_000, 3'b100);
        @(posedge clk); #1 bus_a.frame_start = 1'b1;
        @(posedge clk); #1 bus_a.frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_abort_level", 32'(bus_a.hit_level), 32'd0);
        chk("t1_abort_seg",   32'(bus_a.hit_seg),   32'd0);
        chk("t1_abort_busy",  32'(bus_a.busy),      32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        frame_a("t1_post", 3'b100, 9'b110_000_000, 3'b100);

        // Single hit
        do_reset();
        defaults_a();
        seg_a(3, 8'h45, 1'b1);
        probe_a(PROBE_PLAYER, 8'h45, 1'b1);
        frame_a("t2_single", 3'b001, 9'b000_000_011, 3'b001);

        // Lowest index, shared position, disabled probe, no active segments
        do_reset();
        defaults_a();
        seg_a(1, 8'h22, 1'b1);
        seg_a(5, 8'h22, 1'b1);
        probe_a(PROBE_SWORD, 8'h22, 1'b1);
        frame_a("t3_low1", 3'b010, 9'b000_001_000, 3'b010);
        seg_a(1, 8'h22, 1'b0);
        frame_a("t3_low5", 3'b010, 9'b000_101_000, 3'b000);
        probe_a(PROBE_PLAYER, 8'h22, 1'b1);
        frame_a("t3_same", 3'b011, 9'b000_101_101, 3'b001);
        probe_a(PROBE_PLAYER, 8'h22, 1'b0);
        frame_a("t3_disabled", 3'b010, 9'b000_101_000, 3'b000);
        bus_a.seg_active = '0;
        frame_a("t3_noactive", 3'b000, 9'b000_000_000, 3'b000);

        // Cooldown: persistent hit, pulses in frames 1 and 6
        do_reset();
        defaults_a();
        seg_a(0, 8'h33, 1'b1);
        probe_a(PROBE_PLAYER, 8'h33, 1'b1);
        for (int f = 1; f <= 6; f++) begin
            frame_a($sformatf("t4_f%0d", f), 3'b001, 9'b000_000_000,
                    (f == 1 || f == 6) ? 3'b001 : 3'b000);
        end

        // Overrun and snapshot isolation
        do_reset();
        defaults_a();
        seg_a(2, 8'h77, 1'b1);
        probe_a(PROBE_PLAYER, 8'h77, 1'b1);
        @(posedge clk); #1;
        t0 = cyc;
        bus_a.frame_start = 1'b1;
        chk("t5_busy_t0", 32'(bus_a.busy), 32'd0);
        q_a.push_back('{cyc: t0 + 9, lvl: 3'b001, seg: 9'b000_000_010, pulse: 3'b001, tag: "t5_overrun"});
        @(posedge clk); #1;
        bus_a.frame_start = 1'b0;
        chk("t5_busy_t1", 32'(bus_a.busy), 32'd1);
        @(posedge clk); #1;
        probe_a(PROBE_PLAYER, 8'h78, 1'b1);
        @(posedge clk); #1;
        bus_a.frame_start = 1'b1;
        @(posedge clk); #1;
        bus_a.frame_start = 1'b0;
        chk("t5_overrun_set", 32'(bus_a.overrun), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("t5_busy_publish", 32'(bus_a.busy), 32'd1);
        @(posedge clk); #1;
        chk("t5_busy_done", 32'(bus_a.busy), 32'd0);
        repeat (3) @(posedge clk);
        frame_a("t5_after", 3'b000, 9'b000_000_000, 3'b000);
        chk("t5_overrun_sticky", 32'(bus_a.overrun), 32'd1);

        // Wide configuration against a behavioural model
        do_reset();
        for (int f = 0; f < 1000; f++) begin
            for (int i = 0; i < 16; i++) begin
                bus_b.seg_pos[i*8 +: 8] = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
                bus_b.seg_active[i]     = ($urandom_range(0, 9) < 8);
            end
            for (int p = 0; p < 5; p++) begin
                bus_b.probe_pos[p*8 +: 8] = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
                bus_b.probe_en[p]         = ($urandom_range(0, 9) < 8);
            end
            m_lvl = '0; m_seg = '0; m_pulse = '0;
            for (int p = 0; p < 5; p++) begin
                for (int i = 15; i >= 0; i--) begin
                    if (bus_b.probe_en[p] && bus_b.seg_active[i] &&
                        bus_b.seg_pos[i*8 +: 8] == bus_b.probe_pos[p*8 +: 8]) begin
                        m_lvl[p] = 1'b1;
                        m_seg[p*4 +: 4] = 4'(i);
                    end
                end
                ok = (cool_b[p] == 0);
                if (cool_b[p] > 0) cool_b[p] = cool_b[p] - 1;
                if (m_lvl[p] && ok) begin
                    m_pulse[p] = 1'b1;
                    cool_b[p] = 4;
                end
            end
            frame_b($sformatf("t6_f%0d", f), m_lvl, m_seg, m_pulse);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("q_a_drained", 32'(q_a.size()), 32'd0);
        chk("q_b_drained", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
